// File: rtl/vga_timing_pkg.sv
// Shared raster timing for the 640x480@60 display path (25 MHz pixel clock).
// Coordinate width is common to the sync generator, renderer and ball logic.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;
  // One spare bit so window ends of exactly 1024 still compare correctly.
  typedef logic [COORD_W:0]   coord_ext_t;

  function automatic logic in_window(input coord_ext_t v, input coord_ext_t lo,
                                     input coord_ext_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register; DEPTH=0 degenerates to a plain wire.
// Async active-low clear loads every stage with RST_VAL.
module sync_delay_line #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_En,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  if (DEPTH == 0) begin : g_wire
    assign o_Q = i_D;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_stage <= {DEPTH{RST_VAL}};
      end else if (i_En) begin
        r_stage[0] <= i_D;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_Q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters, registered sync/active decode, line/frame strobes and a
// pixel-enable delay line that realigns syncs with a registered pixel pipeline.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Pix_En,
  output logic [COORD_W-1:0] o_Col,
  output logic [COORD_W-1:0] o_Row,
  output logic               o_Active,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Line_Start,
  output logic               o_Frame_Start,
  output logic               o_Active_D,
  output logic               o_HSync_D,
  output logic               o_VSync_D
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CW1     = COORD_W + 1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY > 7) begin : g_cfg_err
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024 and SYNC_DELAY <= 7");
  end

  localparam coord_t     H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t     V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_ext_t HA     = CW1'(H_ACTIVE);
  localparam coord_ext_t VA     = CW1'(V_ACTIVE);
  localparam coord_ext_t HS_LO  = CW1'(H_ACTIVE + H_FRONT);
  localparam coord_ext_t HS_HI  = CW1'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam coord_ext_t VS_LO  = CW1'(V_ACTIVE + V_FRONT);
  localparam coord_ext_t VS_HI  = CW1'(V_ACTIVE + V_FRONT + V_SYNC);

  coord_t r_col, r_row;
  coord_t w_col_nxt, w_row_nxt;
  logic   w_last_col, w_last_row;
  logic   w_active_nxt, w_hs_nxt, w_vs_nxt;
  logic   r_active, r_hs, r_vs, r_line_start, r_frame_start;

  assign w_last_col = (r_col == H_LAST);
  assign w_last_row = (r_row == V_LAST);
  assign w_col_nxt  = w_last_col ? '0 : r_col + 1'b1;
  assign w_row_nxt  = !w_last_col ? r_row : (w_last_row ? '0 : r_row + 1'b1);

  // Decode the next count so the registered flags land with zero skew to o_Col/o_Row.
  assign w_active_nxt = ({1'b0, w_col_nxt} < HA) && ({1'b0, w_row_nxt} < VA);
  assign w_hs_nxt = in_window({1'b0, w_col_nxt}, HS_LO, HS_HI) ? HS_POL : ~HS_POL;
  assign w_vs_nxt = in_window({1'b0, w_row_nxt}, VS_LO, VS_HI) ? VS_POL : ~VS_POL;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_col         <= '0;
      r_row         <= '0;
      r_active      <= 1'b1;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= i_Pix_En && w_last_col;
      r_frame_start <= i_Pix_En && w_last_col && w_last_row;
      if (i_Pix_En) begin
        r_col    <= w_col_nxt;
        r_row    <= w_row_nxt;
        r_active <= w_active_nxt;
        r_hs     <= w_hs_nxt;
        r_vs     <= w_vs_nxt;
      end
    end
  end

  logic [2:0] w_dly_q;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
  ) u_sync_dly (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_En    (i_Pix_En),
    .i_D     ({r_active, r_hs, r_vs}),
    .o_Q     (w_dly_q)
  );

  assign o_Col         = r_col;
  assign o_Row         = r_row;
  assign o_Active      = r_active;
  assign o_HSync       = r_hs;
  assign o_VSync       = r_vs;
  assign o_Line_Start  = r_line_start;
  assign o_Frame_Start = r_frame_start;
  assign {o_Active_D, o_HSync_D, o_VSync_D} = w_dly_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance (SYNC_DELAY=2) plus a tiny
// 16x8 raster (HS_POL=1, SYNC_DELAY=0) so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic a, h, v, ls, fs, ad, hd, vd;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int d;
  } tm_t;

  typedef struct {
    int c, r;
    bit a, h, v, ls, fs;
    logic [7:0][2:0] dl;
  } mst_t;

  logic clk = 1'b0;
  logic rst_n, en;
  always #5 clk = ~clk;

  logic [9:0] d_col, d_row, s_col, s_row;
  logic d_act, d_hs, d_vs, d_ls, d_fs, d_actd, d_hsd, d_vsd;
  logic s_act, s_hs, s_vs, s_ls, s_fs, s_actd, s_hsd, s_vsd;

  vga_sync_gen u_def (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(en),
    .o_Col(d_col), .o_Row(d_row), .o_Active(d_act), .o_HSync(d_hs), .o_VSync(d_vs),
    .o_Line_Start(d_ls), .o_Frame_Start(d_fs),
    .o_Active_D(d_actd), .o_HSync_D(d_hsd), .o_VSync_D(d_vsd)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .SYNC_DELAY(0)
  ) u_small (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(en),
    .o_Col(s_col), .o_Row(s_row), .o_Active(s_act), .o_HSync(s_hs), .o_VSync(s_vs),
    .o_Line_Start(s_ls), .o_Frame_Start(s_fs),
    .o_Active_D(s_actd), .o_HSync_D(s_hsd), .o_VSync_D(s_vsd)
  );

  int checks = 0, errors = 0;
  obs_t qd[$], qs[$];
  tm_t  td, ts;
  mst_t md, ms;
  int   step = 0;
  bit   phase_a = 0, phase_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic mst_t m_reset(input tm_t t);
    mst_t s;
    s.c = 0; s.r = 0; s.a = 1'b1; s.h = ~t.hp; s.v = ~t.vp; s.ls = 0; s.fs = 0;
    for (int i = 0; i < 8; i++) s.dl[i] = {1'b0, ~t.hp, ~t.vp};
    return s;
  endfunction

  function automatic mst_t m_step(input mst_t s, input tm_t t, input bit e);
    mst_t n;
    int htot, vtot;
    htot = t.ha + t.hf + t.hs + t.hb;
    vtot = t.va + t.vf + t.vs + t.vb;
    n = s; n.ls = 0; n.fs = 0;
    if (e) begin
      n.dl[0] = {s.a, s.h, s.v};
      for (int i = 1; i < 8; i++) n.dl[i] = s.dl[i-1];
      n.c = s.c + 1;
      if (n.c == htot) begin
        n.c = 0; n.ls = 1; n.r = s.r + 1;
        if (n.r == vtot) begin n.r = 0; n.fs = 1; end
      end
      n.a = (n.c < t.ha) && (n.r < t.va);
      n.h = (n.c >= t.ha + t.hf && n.c < t.ha + t.hf + t.hs) ? t.hp : ~t.hp;
      n.v = (n.r >= t.va + t.vf && n.r < t.va + t.vf + t.vs) ? t.vp : ~t.vp;
    end
    return n;
  endfunction

  function automatic obs_t m_obs(input mst_t s, input tm_t t);
    obs_t o;
    o.col = s.c[9:0]; o.row = s.r[9:0];
    o.a = s.a; o.h = s.h; o.v = s.v; o.ls = s.ls; o.fs = s.fs;
    if (t.d == 0) {o.ad, o.hd, o.vd} = {s.a, s.h, s.v};
    else          {o.ad, o.hd, o.vd} = s.dl[t.d-1];
    return o;
  endfunction

  function automatic obs_t dut_d();
    return {d_col, d_row, d_act, d_hs, d_vs, d_ls, d_fs, d_actd, d_hsd, d_vsd};
  endfunction

  function automatic obs_t dut_s();
    return {s_col, s_row, s_act, s_hs, s_vs, s_ls, s_fs, s_actd, s_hsd, s_vsd};
  endfunction

  // Driver: apply enable pattern, advance the model, push expected responses.
  task automatic run(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      bit e;
      e = toggle ? (i % 2 == 0) : 1'b1;
      en = e;
      @(posedge clk);
      md = m_step(md, td, e);
      ms = m_step(ms, ts, e);
      qd.push_back(m_obs(md, td));
      qs.push_back(m_obs(ms, ts));
      if (e) step++;
      #1;
    end
  endtask

  // Monitor: pop and compare every presented cycle.
  initial forever begin
    @(negedge clk);
    if (qd.size() > 0) chk($sformatf("def_cycle_step%0d", step), dut_d(), qd.pop_front());
    if (qs.size() > 0) chk($sformatf("small_cycle_step%0d", step), dut_s(), qs.pop_front());
  end

  int def_hlow = 0, def_act = 0, def_ls_early = 0, def_fs_tot = 0;
  int hs_first = -1, hsd_first = -1, def_ls800 = -1, def_col800 = -1, def_row800 = -1;
  int sm_act = 0, sm_vlow = 0, sm_hhi = 0, sm_fs = 0, ls_b_d = 0, ls_b_s = 0;

  initial forever begin
    @(negedge clk);
    if (phase_a) begin
      if (step < 800) begin
        def_hlow += int'(d_hs == 1'b0);
        def_act  += int'(d_act);
        if (step >= 1) def_ls_early += int'(d_ls);
        if (d_hs == 1'b0 && hs_first < 0)   hs_first  = int'(d_col);
        if (d_hsd == 1'b0 && hsd_first < 0) hsd_first = int'(d_col);
      end
      if (step == 800) begin
        def_ls800 = int'(d_ls); def_col800 = int'(d_col); def_row800 = int'(d_row);
      end
      def_fs_tot += int'(d_fs);
      if (step < 128) begin
        sm_act  += int'(s_act);
        sm_vlow += int'(s_vs == 1'b0);
        sm_hhi  += int'(s_hs);
      end
      sm_fs += int'(s_fs);
    end
    if (phase_b && step >= 1) begin
      ls_b_d += int'(d_ls);
      ls_b_s += int'(s_ls);
    end
  end

  initial begin
    td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
    ts = '{8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b0, 0};
    rst_n = 1'b0; en = 1'b0;
    #12;
    chk("reset_def",   dut_d(), {10'd0, 10'd0, 8'b1110_0011});
    chk("reset_small", dut_s(), {10'd0, 10'd0, 8'b1010_0101});
    md = m_reset(td); ms = m_reset(ts);

    @(posedge clk); #1;
    rst_n = 1'b1; step = 0; phase_a = 1;
    run(1600, 1'b0);
    phase_a = 0;
    chk("hsync_low_clocks_row0", def_hlow, 96);
    chk("active_clocks_row0",    def_act, 640);
    chk("hsync_first_col",       hs_first, 656);
    chk("hsync_d_first_col",     hsd_first, 658);
    chk("line_start_early",      def_ls_early, 0);
    chk("line_start_clk800",     def_ls800, 1);
    chk("col_clk800",            def_col800, 0);
    chk("row_clk800",            def_row800, 1);
    chk("frame_start_def",       def_fs_tot, 0);
    chk("small_active_frame",    sm_act, 32);
    chk("small_vsync_frame",     sm_vlow, 32);
    chk("small_hsync_frame",     sm_hhi, 24);
    chk("small_frame_pulses",    sm_fs, 12);
    chk("def_pos_after_a",       {d_col, d_row}, {10'd0, 10'd2});

    step = 0; phase_b = 1;
    run(1600, 1'b1);
    phase_b = 0;
    chk("def_pos_after_toggle",  {d_col, d_row}, {10'd0, 10'd3});
    chk("toggle_line_pulses",    ls_b_d, 1);
    chk("small_toggle_lines",    ls_b_s, 50);

    run(300, 1'b0);
    chk("def_mid_line",   {d_col, d_row, d_act, d_hs}, {10'd300, 10'd3, 1'b1, 1'b1});
    chk("small_mid_line", {s_col, s_row, s_act, s_hs}, {10'd12, 10'd0, 1'b0, 1'b1});
    #1;
    rst_n = 1'b0;
    qd.delete(); qs.delete();
    #1;
    chk("async_reset_def",   dut_d(), {10'd0, 10'd0, 8'b1110_0011});
    chk("async_reset_small", dut_s(), {10'd0, 10'd0, 8'b1010_0101});
    md = m_reset(td); ms = m_reset(ts);

    @(posedge clk); #1;
    rst_n = 1'b1; step = 0;
    run(20, 1'b0);
    chk("restart_def",   {d_col, d_row}, {10'd20, 10'd0});
    chk("restart_small", {s_col, s_row}, {10'd4, 10'd1});
    @(negedge clk); @(negedge clk);
    chk("queue_drained", qd.size() + qs.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
